// File: rtl/sprite_renderer_if.sv
// Scan-side bus of the sprite renderer: VGA scan position in, texel
// address/data to the animation source, RGB444 pixel out.
interface sprite_renderer_if;
    logic [9:0]  h_cnt;
    logic [9:0]  v_cnt;
    logic        valid;
    logic [9:0]  pos_x;
    logic [9:0]  pos_y;
    logic [7:0]  ram_addr_x;
    logic [7:0]  ram_addr_y;
    logic [15:0] ram_data;
    logic [11:0] rgb;
    logic        frame_start;

    // Driver side: scan generator, sprite placement and texel source.
    modport master (
        output h_cnt, v_cnt, valid, pos_x, pos_y, ram_data,
        input  ram_addr_x, ram_addr_y, rgb, frame_start
    );

    // Renderer side.
    modport slave (
        input  h_cnt, v_cnt, valid, pos_x, pos_y, ram_data,
        output ram_addr_x, ram_addr_y, rgb, frame_start
    );
endinterface

// File: rtl/sprite_renderer.sv
// Two-stage sprite renderer: scan position -> texel address (stage 1),
// texel -> colour-keyed RGB444 pixel (stage 2). The sprite origin is
// captured once per frame at scan (0,0) so mid-frame moves never tear.
module sprite_renderer #(
    parameter logic [7:0]  SPRITE_W = 8'd128,
    parameter logic [7:0]  SPRITE_H = 8'd128,
    parameter int          SCALE    = 2,
    parameter logic [15:0] KEY      = 16'hF81F,
    parameter logic [11:0] BG       = 12'h000
) (
    input  logic             clk,
    input  logic             rst,
    sprite_renderer_if.slave bus
);
    logic [9:0] org_x, org_y;
    logic [9:0] cur_org_x, cur_org_y;
    logic [9:0] dx, dy, tx, ty;
    logic       latch, hit;
    logic       hit1, valid1;

    // Origin bypass: the (0,0) pixel already sees the origin being latched.
    always_comb begin
        latch     = (bus.h_cnt == 10'd0) && (bus.v_cnt == 10'd0);
        cur_org_x = latch ? bus.pos_x : org_x;
        cur_org_y = latch ? bus.pos_y : org_y;
        // Unsigned wrap makes pixels left/above the sprite land far out of range.
        dx        = bus.h_cnt - cur_org_x;
        dy        = bus.v_cnt - cur_org_y;
        tx        = dx >> SCALE;
        ty        = dy >> SCALE;
        hit       = bus.valid && (tx < {2'b00, SPRITE_W}) && (ty < {2'b00, SPRITE_H});
    end

    // Per-frame origin capture and frame_start pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            org_x           <= '0;
            org_y           <= '0;
            bus.frame_start <= 1'b0;
        end else begin
            bus.frame_start <= latch;
            if (latch) begin
                org_x <= bus.pos_x;
                org_y <= bus.pos_y;
            end
        end
    end

    // Stage 1: texel address toward the source, zeroed outside the sprite.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.ram_addr_x <= '0;
            bus.ram_addr_y <= '0;
            hit1           <= 1'b0;
            valid1         <= 1'b0;
        end else begin
            bus.ram_addr_x <= hit ? tx[7:0] : 8'd0;
            bus.ram_addr_y <= hit ? ty[7:0] : 8'd0;
            hit1           <= hit;
            valid1         <= bus.valid;
        end
    end

    // Stage 2: colour key and RGB565 -> RGB444; blanking forces black over BG.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.rgb <= '0;
        end else if (!valid1) begin
            bus.rgb <= 12'h000;
        end else if (!hit1 || bus.ram_data == KEY) begin
            bus.rgb <= BG;
        end else begin
            bus.rgb <= {bus.ram_data[15:12], bus.ram_data[10:7], bus.ram_data[4:1]};
        end
    end
endmodule

// File: tb/tb_sprite_renderer.sv
// Randomised + directed bench for sprite_renderer. Two instances share the
// stimulus: SCALE=2 with a distinctive BG, and SCALE=0 with default BG.
module tb_sprite_renderer;
    localparam logic [15:0] KEY_C = 16'hF81F;
    localparam logic [11:0] BG2   = 12'h3C7;
    localparam logic [11:0] BG0   = 12'h000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sprite_renderer_if bus2 ();
    sprite_renderer_if bus0 ();

    sprite_renderer #(.BG(BG2)) u_dut (.clk(clk), .rst(rst), .bus(bus2));
    sprite_renderer #(.SCALE(0)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));

    int          checks = 0;
    int          errors = 0;
    int          tmode  = 0;
    logic [15:0] tval   = 16'h0000;

    // Texel source: pseudo-image with KEY texels sprinkled in, or a constant.
    function automatic logic [15:0] tex(input logic [7:0] x, input logic [7:0] y,
                                        input int m, input logic [15:0] v);
        logic [15:0] t;
        if (m != 0) return v;
        t = {x, y} ^ {y[4:0], x, y[7:5]} ^ 16'h5A3C;
        if (x[2:0] == y[2:0]) t = KEY_C;
        return t;
    endfunction

    always_comb bus2.ram_data = tex(bus2.ram_addr_x, bus2.ram_addr_y, tmode, tval);
    always_comb bus0.ram_data = tex(bus0.ram_addr_x, bus0.ram_addr_y, tmode, tval);

    typedef struct packed {
        logic [7:0]  ax;
        logic [7:0]  ay;
        logic [11:0] rgb;
    } res_t;

    // Screen-pixel view of the sprite: what one scan position must show.
    function automatic res_t px_model(input logic [9:0] h, input logic [9:0] v, input logic val,
                                      input logic [9:0] ox, input logic [9:0] oy, input int sc,
                                      input logic [11:0] bg, input int m, input logic [15:0] tv);
        res_t        r;
        logic [9:0]  ddx, ddy;
        int          tx, ty;
        logic [15:0] d;
        ddx = h - ox;
        ddy = v - oy;
        tx  = int'(ddx) >> sc;
        ty  = int'(ddy) >> sc;
        if (val && tx < 128 && ty < 128) begin
            r.ax  = tx[7:0];
            r.ay  = ty[7:0];
            d     = tex(r.ax, r.ay, m, tv);
            r.rgb = (d == KEY_C) ? bg : {d[15:12], d[10:7], d[4:1]};
        end else begin
            r.ax  = 8'd0;
            r.ay  = 8'd0;
            r.rgb = val ? bg : 12'h000;
        end
        return r;
    endfunction

    typedef struct {
        logic chk;
        logic rst;
        logic fs;
        res_t e2;
        res_t e0;
    } slot_t;

    slot_t       cur, p1, p2;
    logic [9:0]  morg_x = 10'd0, morg_y = 10'd0;
    logic [9:0]  pos_x = 10'd0, pos_y = 10'd0;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Every-cycle compare: addresses/frame_start one clk behind the scan,
    // pixel two clk behind, forced black if reset hit in between.
    always @(negedge clk) begin
        if (p1.chk) begin
            chk("addr_x_s2", {8'h0, bus2.ram_addr_x}, {8'h0, p1.e2.ax});
            chk("addr_y_s2", {8'h0, bus2.ram_addr_y}, {8'h0, p1.e2.ay});
            chk("addr_x_s0", {8'h0, bus0.ram_addr_x}, {8'h0, p1.e0.ax});
            chk("addr_y_s0", {8'h0, bus0.ram_addr_y}, {8'h0, p1.e0.ay});
            chk("frame_start", {15'h0, bus2.frame_start}, {15'h0, p1.fs});
            if (p2.chk) begin
                chk("rgb_s2", {4'h0, bus2.rgb}, p1.rst ? 16'h0 : {4'h0, p2.e2.rgb});
                chk("rgb_s0", {4'h0, bus0.rgb}, p1.rst ? 16'h0 : {4'h0, p2.e0.rgb});
            end
        end
    end

    task automatic drive(input logic r, input logic [9:0] h, input logic [9:0] v, input logic val);
        p2 = p1;
        p1 = cur;
        rst = r;
        bus2.h_cnt = h;  bus2.v_cnt = v;  bus2.valid = val;  bus2.pos_x = pos_x;  bus2.pos_y = pos_y;
        bus0.h_cnt = h;  bus0.v_cnt = v;  bus0.valid = val;  bus0.pos_x = pos_x;  bus0.pos_y = pos_y;
        if (r) begin
            morg_x = 10'd0;
            morg_y = 10'd0;
        end else if (h == 10'd0 && v == 10'd0) begin
            morg_x = pos_x;
            morg_y = pos_y;
        end
        cur.chk = 1'b1;
        cur.rst = r;
        cur.fs  = !r && h == 10'd0 && v == 10'd0;
        if (r) begin
            cur.e2 = '0;
            cur.e0 = '0;
        end else begin
            cur.e2 = px_model(h, v, val, morg_x, morg_y, 2, BG2, tmode, tval);
            cur.e0 = px_model(h, v, val, morg_x, morg_y, 0, BG0, tmode, tval);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic scan(input logic [9:0] h, input logic [9:0] v);
        drive(1'b0, h, v, (h < 10'd640) && (v < 10'd480));
    endtask

    // Texel source changes only behind a blank pixel so no in-flight pixel sees it.
    task automatic set_tex(input int m, input logic [15:0] v);
        scan(10'd700, 10'd500);
        tmode = m;
        tval  = v;
    endtask

    task automatic chk_addr2(input string nm, input logic [7:0] x, input logic [7:0] y);
        chk({nm, "_x"}, {8'h0, bus2.ram_addr_x}, {8'h0, x});
        chk({nm, "_y"}, {8'h0, bus2.ram_addr_y}, {8'h0, y});
    endtask

    initial begin
        res_t m;
        cur = '{chk: 1'b0, rst: 1'b0, fs: 1'b0, e2: '0, e0: '0};
        p1 = cur;
        p2 = cur;

        // Pin the model on hand-derived points.
        m = px_model(10'd107, 10'd53, 1'b1, 10'd100, 10'd50, 2, BG2, 1, 16'h07E0);
        chk("model_addr", {m.ax, m.ay}, 16'h0100);
        chk("model_rgb", {4'h0, m.rgb}, 16'h00F0);
        m = px_model(10'd99, 10'd50, 1'b1, 10'd100, 10'd50, 2, BG2, 1, 16'hFFFF);
        chk("model_left_miss", {4'h0, m.rgb}, {4'h0, BG2});

        // Reset held while scanning.
        pos_x = 10'd100;  pos_y = 10'd50;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 10'(10 + i), 10'd20, 1'b1);
            chk("rst_rgb", {4'h0, bus2.rgb}, 16'h0);
            chk_addr2("rst_addr", 8'd0, 8'd0);
            chk("rst_fs", {15'h0, bus2.frame_start}, 16'h0);
        end

        // Release, latch origin (100,50), addressing and right-edge boundary.
        scan(10'd5, 10'd5);
        scan(10'd0, 10'd0);
        chk("fs_pulse", {15'h0, bus2.frame_start}, 16'h1);
        scan(10'd100, 10'd50);
        chk("fs_single", {15'h0, bus2.frame_start}, 16'h0);
        chk_addr2("org", 8'd0, 8'd0);
        scan(10'd107, 10'd53);
        chk_addr2("step", 8'd1, 8'd0);
        scan(10'd99, 10'd50);
        chk_addr2("left_miss", 8'd0, 8'd0);
        scan(10'd611, 10'd50);
        chk_addr2("right_edge", 8'd127, 8'd0);
        chk("left_miss_rgb", {4'h0, bus2.rgb}, {4'h0, BG2});
        scan(10'd612, 10'd50);
        chk_addr2("right_out", 8'd0, 8'd0);

        // Colour path: each pixel shows up two clocks after its scan position.
        set_tex(1, 16'hFFFF);
        scan(10'd100, 10'd50);  scan(10'd700, 10'd500);
        chk("white", {4'h0, bus2.rgb}, 16'h0FFF);
        set_tex(1, 16'h07E0);
        scan(10'd100, 10'd50);  scan(10'd700, 10'd500);
        chk("green", {4'h0, bus2.rgb}, 16'h00F0);
        set_tex(1, KEY_C);
        scan(10'd100, 10'd50);  scan(10'd700, 10'd500);
        chk("key", {4'h0, bus2.rgb}, {4'h0, BG2});
        set_tex(1, 16'hFFFF);
        drive(1'b0, 10'd100, 10'd50, 1'b0);  scan(10'd700, 10'd500);
        chk("blank", {4'h0, bus2.rgb}, 16'h0);
        set_tex(0, 16'h0);

        // Tear-free move: new pos_x only takes effect at the next (0,0).
        scan(10'd0, 10'd0);
        pos_x = 10'd300;
        scan(10'd110, 10'd200);
        chk_addr2("tear_old", 8'd2, 8'd37);
        scan(10'd310, 10'd200);
        chk_addr2("tear_old2", 8'd52, 8'd37);
        scan(10'd0, 10'd0);
        scan(10'd310, 10'd200);
        chk_addr2("tear_new", 8'd2, 8'd37);
        scan(10'd110, 10'd200);
        chk_addr2("tear_new_miss", 8'd0, 8'd0);

        // Edge clip on the SCALE=0 instance.
        pos_x = 10'd600;  pos_y = 10'd470;
        scan(10'd0, 10'd0);
        scan(10'd600, 10'd470);
        chk("clip_org", {bus0.ram_addr_x, bus0.ram_addr_y}, 16'h0000);
        scan(10'd639, 10'd479);
        chk("clip_corner", {bus0.ram_addr_x, bus0.ram_addr_y}, {8'd39, 8'd9});
        scan(10'd599, 10'd475);
        chk("clip_left", {bus0.ram_addr_x, bus0.ram_addr_y}, 16'h0000);

        // Mid-frame reset: origin falls back to 0 until the next (0,0).
        pos_x = 10'd300;  pos_y = 10'd100;
        drive(1'b1, 10'd320, 10'd240, 1'b1);
        chk("midrst_rgb", {4'h0, bus2.rgb}, 16'h0);
        scan(10'd8, 10'd4);
        chk_addr2("midrst_org0", 8'd2, 8'd1);
        scan(10'd0, 10'd0);
        scan(10'd304, 10'd100);
        chk_addr2("midrst_resume", 8'd1, 8'd0);

        // Randomised traffic checked cycle by cycle.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 31) == 0) begin
                pos_x = 10'($urandom_range(0, 700));
                pos_y = 10'($urandom_range(0, 500));
            end
            if ($urandom_range(0, 99) == 0)
                set_tex($urandom_range(0, 1), ($urandom_range(0, 2) == 0) ? KEY_C : 16'($urandom));
            if ($urandom_range(0, 15) == 0)
                scan(10'd0, 10'd0);
            else if ($urandom_range(0, 199) == 0)
                drive(1'b1, 10'($urandom_range(0, 799)), 10'($urandom_range(0, 524)), 1'b1);
            else
                scan(10'($urandom_range(0, 799)), 10'($urandom_range(0, 524)));
        end
        scan(10'd700, 10'd500);
        scan(10'd700, 10'd500);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
